// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and constants for the instruction-memory port arbiter
//
// Purpose: state encoding and requester identifiers used by imem_port_arbiter
//          and its round-robin pick helper.
// Ports:   none (package).

package imem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_COMP   = 1'b1;

  // The requester that is not 'id'; with two requesters this is the
  // round-robin successor.
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_rr_pick2.sv
// rtl/imem_port_arbiter_rr_pick2.sv - combinational two-way round-robin pick
//
// Purpose: choose one of two requesters; on a tie the requester that did not
//          receive the last grant wins.
// Ports:
//   valid      in   2  request valids, bit 0 = icache, bit 1 = compressed icache
//   last_grant in   1  requester that was granted most recently
//   winner     out  1  selected requester (meaningful only when any=1)
//   any        out  1  at least one requester is valid

module rr_pick2
  import imem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       winner,
  output logic       any
);

  always_comb begin
    winner = REQ_ICACHE;
    if (valid[0] && valid[1]) begin
      winner = other_req(last_grant);
    end else if (valid[1]) begin
      winner = REQ_COMP;
    end
  end

  assign any = |valid;

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - round-robin arbiter for the shared instruction-memory port
//
// Purpose: shares one memory beat port between the regular icache refill path
//          (requester 0) and the compressed icache refill path (requester 1).
//          One beat outstanding at a time; a requester may lock the port across
//          consecutive beats of a refill, capped at MAX_LOCK beats.
// Ports:
//   clk                               in   clock
//   resetn                            in   asynchronous reset, active-high
//   icache_mem_req_valid/lock/addr    in   requester 0 beat request
//   icache_mem_req_ready/rdata        out  requester 0 beat completion and data
//   comp_mem_req_valid/lock/addr      in   requester 1 beat request
//   comp_mem_req_ready/rdata          out  requester 1 beat completion and data
//   mem_req_valid/addr                out  beat request to memory
//   mem_req_ready/rdata               in   memory beat completion and data
//   grant_id                          out  current port owner
//   busy                              out  arbiter not idle

module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              icache_mem_req_valid,
  input  logic              icache_mem_req_lock,
  input  logic [ADDR_W-1:0] icache_mem_req_addr,
  output logic              icache_mem_req_ready,
  output logic [DATA_W-1:0] icache_mem_req_rdata,
  input  logic              comp_mem_req_valid,
  input  logic              comp_mem_req_lock,
  input  logic [ADDR_W-1:0] comp_mem_req_addr,
  output logic              comp_mem_req_ready,
  output logic [DATA_W-1:0] comp_mem_req_rdata,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_req_rdata,
  output logic              grant_id,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pick_winner;
  logic              pick_any;
  logic              g_valid;
  logic              g_lock;
  logic [ADDR_W-1:0] g_addr;
  logic              beat_done;
  logic              lock_room;

  rr_pick2 u_pick (
    .valid      ({comp_mem_req_valid, icache_mem_req_valid}),
    .last_grant (last_q),
    .winner     (pick_winner),
    .any        (pick_any)
  );

  // Signals of the current grantee.
  assign g_valid = (grant_q == REQ_COMP) ? comp_mem_req_valid : icache_mem_req_valid;
  assign g_lock  = (grant_q == REQ_COMP) ? comp_mem_req_lock  : icache_mem_req_lock;
  assign g_addr  = (grant_q == REQ_COMP) ? comp_mem_req_addr  : icache_mem_req_addr;

  // mem_req_ready only means something while a beat is outstanding.
  assign beat_done = (state_q == ST_BUSY) && mem_req_ready;

  // cnt_q counts beats already completed under this lock, excluding the one
  // finishing now; the lock survives only if one more beat stays under the cap.
  assign lock_room = (32'(cnt_q) + 32'd1) < 32'(MAX_LOCK);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      grant_q <= REQ_ICACHE;
      last_q  <= REQ_COMP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          grant_d = pick_winner;
          addr_d  = (pick_winner == REQ_COMP) ? comp_mem_req_addr : icache_mem_req_addr;
        end
      end
      ST_BUSY: begin
        if (mem_req_ready) begin
          if (g_lock && lock_room) begin
            state_d = ST_LOCKED;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            // Normal release or cap reached: recording the grantee as last
            // grant hands the next tie to the other requester.
            state_d = ST_IDLE;
            last_d  = grant_q;
            cnt_d   = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (g_valid) begin
          state_d = ST_BUSY;
          addr_d  = g_addr;
        end else if (!g_lock) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_req_valid = (state_q == ST_BUSY);
  assign mem_req_addr  = addr_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);

  assign icache_mem_req_ready = beat_done && (grant_q == REQ_ICACHE);
  assign comp_mem_req_ready   = beat_done && (grant_q == REQ_COMP);
  assign icache_mem_req_rdata = icache_mem_req_ready ? mem_req_rdata : '0;
  assign comp_mem_req_rdata   = comp_mem_req_ready   ? mem_req_rdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter

module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        icache_mem_req_valid = 1'b0;
  logic        icache_mem_req_lock = 1'b0;
  logic [31:0] icache_mem_req_addr = '0;
  logic        icache_mem_req_ready;
  logic [31:0] icache_mem_req_rdata;
  logic        comp_mem_req_valid = 1'b0;
  logic        comp_mem_req_lock = 1'b0;
  logic [31:0] comp_mem_req_addr = '0;
  logic        comp_mem_req_ready;
  logic [31:0] comp_mem_req_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_rdata = '0;
  logic        grant_id;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(8)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .icache_mem_req_valid (icache_mem_req_valid),
    .icache_mem_req_lock  (icache_mem_req_lock),
    .icache_mem_req_addr  (icache_mem_req_addr),
    .icache_mem_req_ready (icache_mem_req_ready),
    .icache_mem_req_rdata (icache_mem_req_rdata),
    .comp_mem_req_valid   (comp_mem_req_valid),
    .comp_mem_req_lock    (comp_mem_req_lock),
    .comp_mem_req_addr    (comp_mem_req_addr),
    .comp_mem_req_ready   (comp_mem_req_ready),
    .comp_mem_req_rdata   (comp_mem_req_rdata),
    .mem_req_valid        (mem_req_valid),
    .mem_req_addr         (mem_req_addr),
    .mem_req_ready        (mem_req_ready),
    .mem_req_rdata        (mem_req_rdata),
    .grant_id             (grant_id),
    .busy                 (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a beat on the memory port, checks who owns it, holds it for
  // 'delay' cycles, then completes it with 'data'. exp_n is the number of
  // low-valid cycles expected before issue (counted from the call).
  task automatic do_beat(input string tag, input logic gid, input logic [31:0] addr,
                         input logic [31:0] data, input int delay, input int exp_n);
    int n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_issue"}, 64'(mem_req_valid), 64'd1);
    check({tag, "_wait"}, 64'(n), 64'(exp_n));
    check({tag, "_gid"}, 64'(grant_id), 64'(gid));
    check({tag, "_addr"}, 64'(mem_req_addr), 64'(addr));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {31'd0, mem_req_valid, mem_req_addr}, {31'd0, 1'b1, addr});
    end
    mem_req_ready = 1'b1;
    mem_req_rdata = data;
    #1;
    check({tag, "_rdy"}, 64'({icache_mem_req_ready, comp_mem_req_ready}),
          gid ? 64'h1 : 64'h2);
    check({tag, "_rd_ic"}, 64'(icache_mem_req_rdata), gid ? 64'h0 : 64'(data));
    check({tag, "_rd_cp"}, 64'(comp_mem_req_rdata), gid ? 64'(data) : 64'h0);
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mv"}, 64'(mem_req_valid), 64'd0);
    check({tag, "_ma"}, 64'(mem_req_addr), 64'd0);
    check({tag, "_rdy"}, 64'({icache_mem_req_ready, comp_mem_req_ready}), 64'd0);
    check({tag, "_rd"}, {icache_mem_req_rdata, comp_mem_req_rdata}, 64'd0);
    check({tag, "_gid"}, 64'(grant_id), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_idle_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;

    // Reset state
    do_reset();

    // Single icache beat: valid at cycle 1, ready at cycle 4
    icache_mem_req_valid = 1'b1;
    icache_mem_req_addr  = 32'h100;
    do_beat("t1", 1'b0, 32'h100, 32'hDEADBEEF, 3, 1);
    icache_mem_req_valid = 1'b0;
    check("t1_vlow", 64'(mem_req_valid), 64'd0);

    // Alternation from reset
    do_reset();
    icache_mem_req_valid = 1'b1;
    icache_mem_req_addr  = 32'h200;
    comp_mem_req_valid   = 1'b1;
    comp_mem_req_addr    = 32'h300;
    do_beat("t2a", 1'b0, 32'h200, 32'hA0000200, 1, 1);
    icache_mem_req_valid = 1'b0;
    do_beat("t2b", 1'b1, 32'h300, 32'hB0000300, 0, 1);
    icache_mem_req_valid = 1'b1;
    icache_mem_req_addr  = 32'h210;
    comp_mem_req_addr    = 32'h310;
    do_beat("t2c", 1'b0, 32'h210, 32'hA0000210, 0, 1);
    icache_mem_req_valid = 1'b0;
    do_beat("t2d", 1'b1, 32'h310, 32'hB0000310, 0, 1);
    comp_mem_req_valid = 1'b0;

    // comp locks 4 beats while icache waits
    comp_mem_req_valid = 1'b1;
    comp_mem_req_lock  = 1'b1;
    comp_mem_req_addr  = 32'h400;
    for (int i = 0; i < 4; i++) begin
      do_beat($sformatf("t3_%0d", i), 1'b1, 32'h400 + 32'(4 * i), 32'hC0000000 + 32'(i), 0, 1);
      icache_mem_req_valid = 1'b1;
      icache_mem_req_addr  = 32'h500;
      comp_mem_req_addr    = 32'h400 + 32'(4 * (i + 1));
      comp_mem_req_lock    = (i + 1 < 3);
      if (i < 3) begin
        check($sformatf("t3_held_%0d", i), {62'd0, busy, grant_id}, 64'h3);
        check($sformatf("t3_noreq_%0d", i), 64'(mem_req_valid), 64'd0);
      end else begin
        comp_mem_req_valid = 1'b0;
        check("t3_release", 64'(busy), 64'd0);
      end
    end
    do_beat("t3_ic", 1'b0, 32'h500, 32'h12345678, 0, 1);
    icache_mem_req_valid = 1'b0;

    // Lock cap: icache wants 20 beats, forced out after 8
    icache_mem_req_valid = 1'b1;
    icache_mem_req_lock  = 1'b1;
    icache_mem_req_addr  = 32'h1000;
    for (int k = 0; k < 8; k++) begin
      do_beat($sformatf("t4_%0d", k), 1'b0, 32'h1000 + 32'(4 * k), 32'h40000000 + 32'(k), 0, 1);
      icache_mem_req_addr = 32'h1000 + 32'(4 * (k + 1));
      if (k == 0) begin
        comp_mem_req_valid = 1'b1;
        comp_mem_req_lock  = 1'b0;
        comp_mem_req_addr  = 32'h2000;
      end
    end
    check("t4_cap_idle", 64'(busy), 64'd0);
    do_beat("t4_comp", 1'b1, 32'h2000, 32'h50002000, 0, 1);
    comp_mem_req_valid = 1'b0;
    do_beat("t4_resume", 1'b0, 32'h1020, 32'h40000008, 0, 1);
    icache_mem_req_valid = 1'b0;
    icache_mem_req_lock  = 1'b0;
    @(posedge clk);
    #1;
    check("t4_unlock", 64'(busy), 64'd0);

    // Reset while BUSY
    comp_mem_req_valid = 1'b1;
    comp_mem_req_addr  = 32'h600;
    wait_n = 0;
    @(negedge clk);
    while (!mem_req_valid && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("t5_busy", {62'd0, busy, grant_id}, 64'h3);
    mem_req_ready = 1'b1;
    mem_req_rdata = 32'hAAAA5555;
    resetn = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    resetn = 1'b0;
    do_beat("t5_rearb", 1'b1, 32'h600, 32'h60000600, 1, 1);
    comp_mem_req_valid = 1'b0;

    // Stray mem_req_ready while IDLE
    @(negedge clk);
    mem_req_ready = 1'b1;
    mem_req_rdata = 32'h55;
    #1;
    check("t6_rdy", 64'({icache_mem_req_ready, comp_mem_req_ready}), 64'd0);
    check("t6_rd", {icache_mem_req_rdata, comp_mem_req_rdata}, 64'd0);
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    check("t6_state", {62'd0, busy, mem_req_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
